// File: rtl/fmap_stream_tx.sv
// Frame-store transmitter: captures one HEIGHT x WIDTH feature map written sparsely in raster
// order, then replays it as a gap-free pixel stream with frame_start/frame_end markers.
module fmap_stream_tx #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready_in,
    input  logic                 hold,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 err_drop
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e               state_q;
    logic [AW-1:0]        wr_idx_q, wr_idx_d;
    logic [AW-1:0]        rd_idx_q, rd_idx_d;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 valid_out_q;
    logic                 frame_start_q;
    logic                 frame_end_q;
    logic                 err_drop_q;
    logic                 wr_en;

    logic [DATA_BITS-1:0] mem [N];

    assign wr_idx_d = (wr_idx_q == LAST) ? '0 : wr_idx_q + AW'(1);
    assign rd_idx_d = (rd_idx_q == LAST) ? '0 : rd_idx_q + AW'(1);
    assign wr_en    = (state_q == FILL) && valid_in;

    // Frame memory is deliberately left out of reset; a stale frame is never read
    // because reset also returns the FSM to FILL with both indices at zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            err_drop_q    <= 1'b0;
        end else begin
            valid_out_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            err_drop_q    <= 1'b0;
            case (state_q)
                FILL: begin
                    if (valid_in) begin
                        wr_idx_q <= wr_idx_d;
                        if (wr_idx_q == LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    err_drop_q <= valid_in;
                    if (!hold) begin
                        data_out_q    <= mem[rd_idx_q];
                        valid_out_q   <= 1'b1;
                        frame_start_q <= (rd_idx_q == '0);
                        frame_end_q   <= (rd_idx_q == LAST);
                        rd_idx_q      <= rd_idx_d;
                        if (rd_idx_q == LAST) begin
                            state_q <= FILL;
                        end
                    end
                end
            endcase
        end
    end

    assign ready_in    = (state_q == FILL);
    assign data_out    = data_out_q;
    assign valid_out   = valid_out_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench for fmap_stream_tx: scenario table for fill/drain frames plus hand-written
// sequences for power-up reset and an asynchronous reset in the middle of a drain.
module tb_fmap_stream_tx;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int DB = 12;
    localparam int N  = W * H;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [DB-1:0] data_in;
    logic          ready_in;
    logic          hold;
    logic [DB-1:0] data_out;
    logic          valid_out;
    logic          frame_start;
    logic          frame_end;
    logic          err_drop;

    int checks   = 0;
    int failures = 0;

    fmap_stream_tx #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ready_in    (ready_in),
        .hold        (hold),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .err_drop    (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int base;      // first pixel value of the frame (pixels are base..base+N-1)
        int duty;      // valid_in duty in percent while filling
        int hold_pix;  // assert hold when this pixel index is next (-1 = never)
        int hold_len;  // number of held cycles
        int drop_pix;  // pulse valid_in when this pixel index is next (-1 = never)
        int exp_gaps;  // expected cycles with valid_out low inside the frame
        int exp_errs;  // expected err_drop pulses during the drain
    } scen_t;

    scen_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_frame(input int base, input int duty);
        int cnt = 0;
        int cyc = 0;
        bit vin;
        while (cnt < N && cyc < 3000) begin
            vin      = (duty >= 100) || (int'($urandom_range(99)) < duty);
            valid_in = vin;
            data_in  = DB'(base + cnt);
            hold     = 1'($urandom_range(1));
            chk("fill_ready", int'(ready_in), 1);
            chk("fill_valid", int'(valid_out), 0);
            tick();
            cyc++;
            if (vin) cnt++;
        end
        if (cnt < N) chk("fill_timeout", cnt, N);
        valid_in = 1'b0;
        hold     = 1'b0;
        chk("ready_after_fill", int'(ready_in), 0);
        chk("valid_before_p0", int'(valid_out), 0);
    endtask

    task automatic drain_frame(input scen_t s);
        int idx = 0;
        int gaps = 0;
        int errs = 0;
        int held = 0;
        int cyc = 0;
        bit dropped = 1'b0;
        while (idx < N && cyc < 1000) begin
            hold = (idx == s.hold_pix) && (held < s.hold_len);
            if (hold) held++;
            if (idx == s.drop_pix && !dropped) begin
                valid_in = 1'b1;
                data_in  = 12'hABC;
                dropped  = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            tick();
            if (cyc == 0) chk("p0_latency", int'(valid_out), 1);
            cyc++;
            if (err_drop) errs++;
            if (valid_out) begin
                chk("data", int'(data_out), s.base + idx);
                chk("frame_start", int'(frame_start), int'(idx == 0));
                chk("frame_end", int'(frame_end), int'(idx == N - 1));
                if (idx == N - 1) chk("ready_at_end", int'(ready_in), 1);
                idx++;
            end else begin
                if (idx > 0) chk("hold_data", int'(data_out), s.base + idx - 1);
                chk("gap_markers", int'(frame_start | frame_end), 0);
                gaps++;
            end
        end
        if (idx < N) chk("drain_timeout", idx, N);
        chk("gaps", gaps, s.exp_gaps);
        chk("err_pulses", errs, s.exp_errs);
        valid_in = 1'b0;
        hold     = 1'b0;
        tick();
        chk("idle_valid", int'(valid_out), 0);
        chk("idle_ready", int'(ready_in), 1);
        chk("idle_err", int'(err_drop), 0);
    endtask

    initial begin
        int seen;
        int cyc;

        tbl[0] = '{base: 0,   duty: 100, hold_pix: -1, hold_len: 0, drop_pix: -1, exp_gaps: 0, exp_errs: 0};
        tbl[1] = '{base: 0,   duty: 40,  hold_pix: -1, hold_len: 0, drop_pix: -1, exp_gaps: 0, exp_errs: 0};
        tbl[2] = '{base: 0,   duty: 100, hold_pix: 50, hold_len: 3, drop_pix: -1, exp_gaps: 3, exp_errs: 0};
        tbl[3] = '{base: 0,   duty: 100, hold_pix: -1, hold_len: 0, drop_pix: 20, exp_gaps: 0, exp_errs: 1};
        tbl[4] = '{base: 200, duty: 100, hold_pix: -1, hold_len: 0, drop_pix: -1, exp_gaps: 0, exp_errs: 0};

        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        hold     = 1'b0;
        tick();
        tick();
        chk("rst_ready", int'(ready_in), 1);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_markers", int'({frame_start, frame_end}), 0);
        chk("rst_err", int'(err_drop), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            fill_frame(tbl[i].base, tbl[i].duty);
            drain_frame(tbl[i]);
        end

        // Asynchronous reset mid-drain, applied away from any clock edge.
        fill_frame(0, 100);
        seen = 0;
        cyc  = 0;
        while (seen < 70 && cyc < 500) begin
            tick();
            cyc++;
            if (valid_out) seen++;
        end
        chk("pre_reset_pixels", seen, 70);
        chk("pre_reset_valid", int'(valid_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ready", int'(ready_in), 1);
        chk("async_valid", int'(valid_out), 0);
        chk("async_data", int'(data_out), 0);
        chk("async_markers", int'({frame_start, frame_end}), 0);
        chk("async_err", int'(err_drop), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_frame(500, 100);
        drain_frame('{base: 500, duty: 100, hold_pix: -1, hold_len: 0, drop_pix: -1,
                      exp_gaps: 0, exp_errs: 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
